rggen_bit_field_rws_set_arbiter: RTL and testbench
==================================================

# rggen_bit_field_rws_set_arbiter

Shares the hardware-set port (`i_set` / `i_value`) of a single RWS bit field among `REQUESTERS` hardware agents. Each agent raises a request with a value and holds it until acknowledged. The arbiter picks one winner round-robin, latches its value, and drives the field's set port for exactly one cycle. Set issue is deferred while a bus write to the same field is in progress, so bus writes are not silently overridden; a bounded defer limit guarantees forward progress.

## Interface
- `WIDTH`, default 8: field width; must match the driven RWS field.
- `REQUESTERS`, default 2: number of hardware agents; must be ≥1.
- `DEFER_LIMIT`, default 4: consecutive deferred ISSUE cycles before a set is forced. 0 means never force.
- `i_clk`, input, 1: clock. All state updates on the rising edge.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_req`, input, `REQUESTERS`: per-agent set request. Held high until the matching `o_ack`.
- `i_value`, input, `REQUESTERS*WIDTH`: per-agent set value. Agent k occupies bits `[k*WIDTH +: WIDTH]`. Stable while its `i_req` is high.
- `i_bus_valid`, input, 1: bus access to the target field this cycle. Connect to the field's `bit_field_if.valid`.
- `o_ack`, output, `REQUESTERS`: one-hot, one-cycle acknowledge; asserted in the cycle the winner's value is set.
- `o_set`, output, 1: connect to the field's `i_set`.
- `o_value`, output, `WIDTH`: connect to the field's `i_value`; holds the latched winner value.
- `o_busy`, output, 1: high while in ISSUE.

## Operation
- States: IDLE, ISSUE. Reset state is IDLE.
- Registers:
  - `grant`: index of the current winner.
  - `last`: index of the last winner; reset value `REQUESTERS-1`, so agent 0 has first priority.
  - `hold`: latched value, `WIDTH` bits; reset value 0.
  - `defer_cnt`: width `$clog2(DEFER_LIMIT+1)`, minimum 1 bit; reset value 0.
- IDLE:
  - If `i_req` is nonzero, the winner is the first asserted requester scanning `last+1, last+2, …` with wrap modulo `REQUESTERS`.
  - On the clock edge: `grant` ← winner, `hold` ← the winner's `i_value` slice, `defer_cnt` ← 0, next state ISSUE.
  - If `i_req` is zero, stay in IDLE.
- ISSUE:
  - `fire = !i_bus_valid || (DEFER_LIMIT != 0 && defer_cnt == DEFER_LIMIT)`. Combinational; the only combinational input→output path.
  - `fire` = 1: `o_set` = 1 and `o_ack[grant]` = 1 this cycle. On the edge: `last` ← `grant`, next state IDLE.
  - `fire` = 0: `o_set` = 0, `o_ack` = 0, `defer_cnt` increments (saturating), stay in ISSUE.
- `o_value` = `hold` in every state. `o_set` and `o_ack` are 0 in IDLE.
- Requests arriving or dropping while in ISSUE have no effect on the current grant. The latched `hold` is what gets set, even if the winner's `i_value` changes.
- Dropping `i_req` before ack is a protocol violation; the latched set still issues and is acked.
- With `REQUESTERS` = 1 the round-robin logic degenerates to a direct grant.
- Reset asserted mid-ISSUE:
  - Immediately returns to IDLE.
  - `o_set`, `o_ack` and `o_busy` go to 0 without any set or ack being issued.
  - `hold`, `last` and `defer_cnt` return to their reset values.

## Timing
- Reset values: `o_set` = 0, `o_ack` = 0, `o_busy` = 0, `o_value` = 0.
- Latency: request sampled in IDLE at cycle t; `o_set`/`o_ack` in cycle t+1 when `i_bus_valid` = 0. The field holds the new value from cycle t+2.
- Each deferred cycle adds 1 cycle of latency.
- Worst case with `DEFER_LIMIT` = D > 0: set issued in cycle t+1+D.
- Throughput: at most one set per 2 cycles. An agent releases `i_req` on the edge where it sees `o_ack`, so it is low in the following IDLE cycle.
- Because the field gives `i_set` priority over bus writes, a forced set during `i_bus_valid` overrides that bus write. This is intentional.

## Test plan
- **Single request, reset release.** WIDTH=8, N=2, D=4. Agent 1 requests `8'hA5` with bus idle.
  - Required: `o_set`, `o_ack` = `2'b10` and `o_value` = `8'hA5` one cycle after the request is sampled; field reads `8'hA5` the next cycle; `o_busy` drops.
- **Round-robin fairness.** Agents 0 and 1 hold requests continuously, each re-raising 1 cycle after its ack.
  - Required: ack order 0, 1, 0, 1; set values alternate between the two agents' values; no agent is acked twice in a row.
- **Bus deferral.** `i_bus_valid` is high for 2 cycles starting at the ISSUE cycle.
  - Required: `o_set` stays 0 for 2 cycles, then fires in the 3rd; the bus write data is visible in the field before the set value.
- **Forced issue.** D=4, `i_bus_valid` held high indefinitely.
  - Required: `o_set` asserts on the 5th ISSUE cycle (`defer_cnt` = 4); the set value wins over the bus write. With D=0, `o_set` never asserts until `i_bus_valid` drops.
- **Value latching.** The winner changes `i_value` from `8'h3C` to `8'hFF` during deferral.
  - Required: `o_value` = `8'h3C` when set fires.
- **Reset mid-ISSUE.** Assert `i_rst_n` = 0 while deferred.
  - Required: `o_set`, `o_ack` and `o_busy` go to 0 asynchronously and `o_value` = 0. After release, a new request from agent 0 is granted first.

Source files
------------

// File: rtl/rggen_bit_field_rws_set_arbiter.sv
// rggen_bit_field_rws_set_arbiter: round-robin sharing of one RWS field's hardware-set port,
// deferring sets while a bus access to the field is in progress (bounded by DEFER_LIMIT).
module rggen_bit_field_rws_set_arbiter #(
    parameter int WIDTH       = 8,
    parameter int REQUESTERS  = 2,
    parameter int DEFER_LIMIT = 4
)(
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [REQUESTERS-1:0]         i_req,
    input  logic [REQUESTERS*WIDTH-1:0]   i_value,
    input  logic                          i_bus_valid,
    output logic [REQUESTERS-1:0]         o_ack,
    output logic                          o_set,
    output logic [WIDTH-1:0]              o_value,
    output logic                          o_busy
);
    localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int CW = (DEFER_LIMIT > 0) ? $clog2(DEFER_LIMIT + 1) : 1;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t          r_state, w_next;
    logic [IW-1:0]   r_grant, r_last, w_winner;
    logic [WIDTH-1:0] r_hold;
    logic [CW-1:0]   r_defer_cnt;
    logic            w_found, w_fire;

    // first asserted requester after the last winner, wrapping around
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        for (int i = 1; i <= REQUESTERS; i++) begin
            if (!w_found && |(i_req & (REQUESTERS'(1) << ((int'(r_last) + i) % REQUESTERS)))) begin
                w_found  = 1'b1;
                w_winner = IW'((int'(r_last) + i) % REQUESTERS);
            end
        end
    end

    always_comb begin
        w_fire = (r_state == ISSUE) && (!i_bus_valid || (DEFER_LIMIT != 0 && r_defer_cnt == CW'(DEFER_LIMIT)));
        w_next = (r_state == IDLE) ? (w_found ? ISSUE : IDLE) : (w_fire ? IDLE : ISSUE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_last      <= IW'(REQUESTERS - 1);
            r_hold      <= '0;
            r_defer_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_found) begin
                r_grant     <= w_winner;
                r_hold      <= WIDTH'(i_value >> (int'(w_winner) * WIDTH));
                r_defer_cnt <= '0;
            end else if (w_fire) begin
                r_last <= r_grant;
            end else if (r_state == ISSUE && r_defer_cnt != '1) begin
                r_defer_cnt <= r_defer_cnt + 1'b1;
            end
        end
    end

    assign o_set   = w_fire;
    assign o_ack   = w_fire ? (REQUESTERS'(1) << r_grant) : '0;
    assign o_busy  = (r_state == ISSUE);
    assign o_value = r_hold;
endmodule

// File: tb/tb_rggen_bit_field_rws_set_arbiter.sv
// tb_rggen_bit_field_rws_set_arbiter: directed scenarios plus randomized agents checked against a
// transaction-level reference model; a second instance covers DEFER_LIMIT = 0.
module tb_rggen_bit_field_rws_set_arbiter;
    localparam int N = 2;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [N-1:0] req;
    logic [2*8-1:0] val;
    logic        bus;
    logic [7:0]  bus_data;
    logic [N-1:0] ack;
    logic        set;
    logic [7:0]  value;
    logic        busy;
    logic [7:0]  fld;

    logic [N-1:0] req0;
    logic [15:0] val0;
    logic        bus0;
    logic [N-1:0] ack0;
    logic        set0;
    logic [7:0]  value0;
    logic        busy0;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic        m_busy;
    int          m_grant, m_last, m_wait;
    logic [7:0]  m_hold;
    logic [N-1:0] m_ack_seen;
    int          ack_q[$];
    logic [7:0]  set_q[$];

    always #5 clk = ~clk;

    rggen_bit_field_rws_set_arbiter #(.WIDTH(8), .REQUESTERS(N), .DEFER_LIMIT(D)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_value(val), .i_bus_valid(bus),
        .o_ack(ack), .o_set(set), .o_value(value), .o_busy(busy)
    );

    rggen_bit_field_rws_set_arbiter #(.WIDTH(8), .REQUESTERS(N), .DEFER_LIMIT(0)) u_dut_d0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req0), .i_value(val0), .i_bus_valid(bus0),
        .o_ack(ack0), .o_set(set0), .o_value(value0), .o_busy(busy0)
    );

    // the RWS field being driven: hardware set has priority over a bus write
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) fld <= 8'h00;
        else if (set) fld <= value;
        else if (bus) fld <= bus_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_grant = 0;
        m_last = N - 1;
        m_wait = 0;
        m_hold = 8'h00;
        m_ack_seen = '0;
    endtask

    // one clock cycle: inputs already driven after the negedge
    task automatic cyc();
        logic e_set;
        logic [N-1:0] e_ack;
        #1;
        e_set = m_busy && (!bus || m_wait == D);
        e_ack = e_set ? N'(1 << m_grant) : '0;
        chk("set", 32'(set), 32'(e_set));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("value", 32'(value), 32'(m_hold));
        chk("busy", 32'(busy), 32'(m_busy));
        m_ack_seen = e_ack;
        if (set) begin
            ack_q.push_back(ack[1] ? 1 : 0);
            set_q.push_back(value);
        end
        @(posedge clk);
        if (!m_busy) begin
            if (req != '0) begin
                for (int i = 1; i <= N; i++) begin
                    int k = (m_last + i) % N;
                    if (req[k]) begin
                        m_grant = k;
                        break;
                    end
                end
                m_hold = val[m_grant*8 +: 8];
                m_busy = 1'b1;
                m_wait = 0;
            end
        end else if (e_set) begin
            m_last = m_grant;
            m_busy = 1'b0;
        end else begin
            m_wait++;
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req = '0; val = '0; bus = 1'b0; bus_data = '0;
        req0 = '0; val0 = '0; bus0 = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_set", 32'(set), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_value", 32'(value), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single request from agent 1
        req = 2'b10; val = {8'hA5, 8'h00};
        cyc();
        #1;
        chk("single_set", 32'(set), 1);
        chk("single_ack", 32'(ack), 32'h2);
        chk("single_value", 32'(value), 32'hA5);
        cyc();
        req = '0;
        #1;
        chk("single_field", 32'(fld), 32'hA5);
        chk("single_busy", 32'(busy), 0);
        cyc();

        // round robin with both agents re-raising one cycle after their ack
        ack_q.delete(); set_q.delete();
        val = {8'h22, 8'h11};
        m_ack_seen = '0;
        for (int c = 0; c < 8; c++) begin
            req = ~m_ack_seen;
            cyc();
        end
        req = '0;
        cyc();
        chk("rr_count", 32'(ack_q.size()), 4);
        for (int i = 0; i < 4 && i < ack_q.size(); i++) begin
            chk("rr_order", 32'(ack_q[i]), 32'(i % 2));
            chk("rr_value", 32'(set_q[i]), (i % 2) ? 32'h22 : 32'h11);
        end

        // bus deferral for two ISSUE cycles
        req = 2'b01; val = {8'h00, 8'h5A};
        cyc();
        bus = 1'b1; bus_data = 8'h77;
        #1 chk("defer1_set", 32'(set), 0);
        cyc();
        #1 chk("defer2_set", 32'(set), 0);
        cyc();
        bus = 1'b0;
        #1;
        chk("defer_fire", 32'(set), 1);
        chk("defer_busfirst", 32'(fld), 32'h77);
        cyc();
        req = '0;
        #1 chk("defer_field", 32'(fld), 32'h5A);
        cyc();

        // forced issue with bus held high
        req = 2'b10; val = {8'hC3, 8'h00}; bus = 1'b1; bus_data = 8'h44;
        cyc();
        for (int i = 1; i <= D; i++) begin
            #1 chk("force_wait", 32'(set), 0);
            cyc();
        end
        #1;
        chk("force_set", 32'(set), 1);
        chk("force_ack", 32'(ack), 32'h2);
        cyc();
        req = '0; bus = 1'b0;
        #1 chk("force_field", 32'(fld), 32'hC3);
        cyc();

        // value latched despite i_value change during deferral
        req = 2'b01; val = {8'h00, 8'h3C};
        cyc();
        bus = 1'b1; val = {8'h00, 8'hFF};
        cyc();
        cyc();
        bus = 1'b0;
        #1;
        chk("latch_set", 32'(set), 1);
        chk("latch_value", 32'(value), 32'h3C);
        cyc();
        req = '0;
        cyc();

        // asynchronous reset while deferred; agent 0 won last so agent 1 is next
        req = 2'b10; val = {8'h99, 8'h00};
        cyc();
        bus = 1'b1;
        cyc();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_set", 32'(set), 0);
        chk("arst_ack", 32'(ack), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_value", 32'(value), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; bus = 1'b0; req = 2'b11; val = {8'h99, 8'h12};
        cyc();
        #1;
        chk("arst_first_ack", 32'(ack), 32'h1);
        chk("arst_first_value", 32'(value), 32'h12);
        cyc();
        req = '0;
        cyc();

        // DEFER_LIMIT = 0 never forces
        req0 = 2'b01; val0 = {8'h00, 8'h66}; bus0 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1 chk("d0_hold", 32'(set0), 0);
            @(negedge clk);
        end
        bus0 = 1'b0;
        #1;
        chk("d0_set", 32'(set0), 1);
        chk("d0_value", 32'(value0), 32'h66);
        @(negedge clk);
        req0 = '0;
        @(negedge clk);

        // randomized agents against the model
        m_ack_seen = '0;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < N; k++) begin
                if (m_ack_seen[k]) req[k] = 1'b0;
                else if (!req[k] && $urandom_range(0, 2) == 0) begin
                    req[k] = 1'b1;
                    val[k*8 +: 8] = 8'($urandom);
                end else if (req[k] && $urandom_range(0, 7) == 0) val[k*8 +: 8] = 8'($urandom);
            end
            bus = ($urandom_range(0, 9) < 6);
            bus_data = 8'($urandom);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
